// File: rtl/ftdi_fifo_bridge.sv
// FT2232-style asynchronous FIFO bus bridged to two internal circular queues with burst-limited arbitration.
// Optional build macro FTDI_XFER_COUNT_EN adds the rd_xfer_cnt / wr_xfer_cnt transfer counters.
module ftdi_fifo_bridge #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RDQ_DEPTH   = 1024,
  parameter int unsigned WRQ_DEPTH   = 1024,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned BURST_MAX   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rd_clear,
  input  logic                       wr_clear,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic                       txe,
  input  logic                       rxf,
  input  logic [DATA_W-1:0]          adbus_in,
  output logic [DATA_W-1:0]          adbus_out,
  output logic                       adbus_tri,
  output logic                       ftdi_rd,
  output logic                       ftdi_wr,
  input  logic                       wrreq,
  input  logic [DATA_W-1:0]          data_wr,
  input  logic                       rdreq,
  output logic [DATA_W-1:0]          data_rd,
  output logic                       rdq_full,
  output logic                       rdq_empty,
  output logic                       wrq_full,
  output logic                       wrq_empty,
  output logic [$clog2(RDQ_DEPTH):0] rd_qsize,
  output logic [$clog2(WRQ_DEPTH):0] wr_qsize,
  output logic                       busy
`ifdef FTDI_XFER_COUNT_EN
  ,
  output logic [31:0]                rd_xfer_cnt,
  output logic [31:0]                wr_xfer_cnt
`endif
);

  localparam int unsigned RAW     = $clog2(RDQ_DEPTH);
  localparam int unsigned WAW     = $clog2(WRQ_DEPTH);
  localparam int unsigned RQ_CW   = RAW + 1;
  localparam int unsigned WQ_CW   = WAW + 1;
  localparam int unsigned REC_CYC = (RECOVER_CYC > SYNC_STAGES) ? RECOVER_CYC : SYNC_STAGES;
  localparam int unsigned CYC_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned CYC_MAX = (CYC_A > REC_CYC) ? CYC_A : REC_CYC;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD_STROBE,
    RECOVER
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BURST_W-1:0]   burst_cnt, burst_next;
  logic                 last_wr, last_wr_next;
  logic                 take_wr;
  logic                 tri_next, wr_next, rd_next, busy_next;

  logic [SYNC_STAGES-1:0] txe_sync, rxf_sync;
  logic                   txe_s, rxf_s;
  logic                   rd_elig, wr_elig;

  logic [DATA_W-1:0] wmem [WRQ_DEPTH];
  logic [DATA_W-1:0] rmem [RDQ_DEPTH];
  logic [WAW-1:0]    wq_wptr, wq_rptr;
  logic [RAW-1:0]    rq_wptr, rq_rptr;
  logic [WQ_CW-1:0]  wq_cnt_next;
  logic [RQ_CW-1:0]  rq_cnt_next;
  logic              wq_push, wq_pop, rq_push, rq_push_ok, rq_pop;

  // Flag synchronisers; reset loads the inactive level
  always_ff @(posedge clock) begin
    if (!reset) begin
      txe_sync <= '1;
      rxf_sync <= '1;
    end else begin
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], txe};
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], rxf};
    end
  end

  assign txe_s   = txe_sync[SYNC_STAGES-1];
  assign rxf_s   = rxf_sync[SYNC_STAGES-1];
  assign rd_elig = rd_en && !rxf_s && !rdq_full;
  assign wr_elig = wr_en && !txe_s && !wrq_empty;

  // Write queue: user pushes, FSM pops
  assign wq_push = wrreq && !wrq_full;

  always_comb begin
    wq_cnt_next = wr_qsize;
    if (wq_push && !wq_pop) wq_cnt_next = wr_qsize + 1'b1;
    else if (!wq_push && wq_pop) wq_cnt_next = wr_qsize - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset || wr_clear) begin
      wq_wptr   <= '0;
      wq_rptr   <= '0;
      wr_qsize  <= '0;
      wrq_full  <= 1'b0;
      wrq_empty <= 1'b1;
    end else begin
      if (wq_push) wq_wptr <= wq_wptr + 1'b1;
      if (wq_pop)  wq_rptr <= wq_rptr + 1'b1;
      wr_qsize  <= wq_cnt_next;
      wrq_full  <= (wq_cnt_next == WQ_CW'(WRQ_DEPTH));
      wrq_empty <= (wq_cnt_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && wq_push) wmem[wq_wptr] <= data_wr;
  end

  // Read queue: FSM pushes captured bytes, user pops
  assign rq_push_ok = rq_push && !rdq_full;
  assign rq_pop     = rdreq && !rdq_empty;

  always_comb begin
    rq_cnt_next = rd_qsize;
    if (rq_push_ok && !rq_pop) rq_cnt_next = rd_qsize + 1'b1;
    else if (!rq_push_ok && rq_pop) rq_cnt_next = rd_qsize - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset || rd_clear) begin
      rq_wptr   <= '0;
      rq_rptr   <= '0;
      rd_qsize  <= '0;
      rdq_full  <= 1'b0;
      rdq_empty <= 1'b1;
    end else begin
      if (rq_push_ok) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)     rq_rptr <= rq_rptr + 1'b1;
      rd_qsize  <= rq_cnt_next;
      rdq_full  <= (rq_cnt_next == RQ_CW'(RDQ_DEPTH));
      rdq_empty <= (rq_cnt_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !rd_clear && rq_push_ok) rmem[rq_wptr] <= adbus_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) data_rd <= '0;
    else if (rq_pop && !rd_clear) data_rd <= rmem[rq_rptr];
  end

  // FSM state and registered bus outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      burst_cnt <= '0;
      last_wr   <= 1'b0;
      adbus_tri <= 1'b0;
      ftdi_wr   <= 1'b1;
      ftdi_rd   <= 1'b1;
      busy      <= 1'b0;
      adbus_out <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      burst_cnt <= burst_next;
      last_wr   <= last_wr_next;
      adbus_tri <= tri_next;
      ftdi_wr   <= wr_next;
      ftdi_rd   <= rd_next;
      busy      <= busy_next;
      if (wq_pop) adbus_out <= wmem[wq_rptr];
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    burst_next   = burst_cnt;
    last_wr_next = last_wr;
    take_wr      = 1'b0;
    wq_pop       = 1'b0;
    rq_push      = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rd_elig || wr_elig) begin
          // Keep the current direction until its burst allowance is used up
          if (rd_elig && wr_elig) take_wr = (burst_cnt < BURST_W'(BURST_MAX)) ? last_wr : !last_wr;
          else take_wr = wr_elig;
          if (take_wr != last_wr) burst_next = BURST_W'(1);
          else if (burst_cnt < BURST_W'(BURST_MAX)) burst_next = burst_cnt + 1'b1;
          last_wr_next = take_wr;
          if (take_wr) begin
            state_next = WR_SETUP;
            wq_pop     = 1'b1;
          end else begin
            state_next = RD_STROBE;
          end
        end
      end
      WR_SETUP: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_next = WR_STROBE;
          cnt_next   = '0;
        end
      end
      WR_STROBE: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          state_next = RECOVER;
          cnt_next   = '0;
        end
      end
      RD_STROBE: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          state_next = RECOVER;
          cnt_next   = '0;
          rq_push    = 1'b1;
        end
      end
      RECOVER: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(REC_CYC - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    tri_next  = (state_next == WR_SETUP) || (state_next == WR_STROBE);
    wr_next   = (state_next != WR_STROBE);
    rd_next   = (state_next != RD_STROBE);
    busy_next = (state_next != IDLE);
  end

`ifdef FTDI_XFER_COUNT_EN
  // Completed-transfer counters, independent of queue clears
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_xfer_cnt <= '0;
      wr_xfer_cnt <= '0;
    end else begin
      if (rq_push) rd_xfer_cnt <= rd_xfer_cnt + 32'd1;
      if (state == WR_STROBE && cnt == CNT_W'(STROBE_CYC - 1)) wr_xfer_cnt <= wr_xfer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Bench for ftdi_fifo_bridge: transaction-level model with per-cycle compare, directed scenarios and random traffic.
module tb_ftdi_fifo_bridge;

  localparam int unsigned DW     = 8;
  localparam int unsigned RD     = 16;
  localparam int unsigned WD     = 16;
  localparam int unsigned SETUP  = 1;
  localparam int unsigned STROBE = 2;
  localparam int unsigned RECOV  = 2;
  localparam int unsigned BURST  = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned REC    = (RECOV > SYNC) ? RECOV : SYNC;
  localparam logic [7:0]  CH_R   = 8'h52;
  localparam logic [7:0]  CH_W   = 8'h57;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rd_clear = 1'b0, wr_clear = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic txe = 1'b1, rxf = 1'b1, wrreq = 1'b0, rdreq = 1'b0;
  logic [DW-1:0] adbus_in = '0, data_wr = '0;
  logic [DW-1:0] adbus_out, data_rd;
  logic adbus_tri, ftdi_rd, ftdi_wr, busy;
  logic rdq_full, rdq_empty, wrq_full, wrq_empty;
  logic [$clog2(RD):0] rd_qsize;
  logic [$clog2(WD):0] wr_qsize;

  ftdi_fifo_bridge #(
    .DATA_W(DW), .RDQ_DEPTH(RD), .WRQ_DEPTH(WD), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE),
    .RECOVER_CYC(RECOV), .BURST_MAX(BURST), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset), .rd_clear(rd_clear), .wr_clear(wr_clear),
    .rd_en(rd_en), .wr_en(wr_en), .txe(txe), .rxf(rxf), .adbus_in(adbus_in),
    .adbus_out(adbus_out), .adbus_tri(adbus_tri), .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr),
    .wrreq(wrreq), .data_wr(data_wr), .rdreq(rdreq), .data_rd(data_rd),
    .rdq_full(rdq_full), .rdq_empty(rdq_empty), .wrq_full(wrq_full), .wrq_empty(wrq_empty),
    .rd_qsize(rd_qsize), .wr_qsize(wr_qsize), .busy(busy)
  );

  always #5 clock = ~clock;

  // One entry per future cycle: the bus lines a transfer shows, and whether the read byte is taken then
  typedef struct packed {
    logic drv;
    logic wr;
    logic rd;
    logic bsy;
    logic cap;
  } step_t;

  logic [DW-1:0] m_wq[$];
  logic [DW-1:0] m_rq[$];
  step_t         m_sched[$];
  logic          txe_h[SYNC];
  logic          rxf_h[SYNC];
  logic          m_last_wr;
  int            m_run;
  logic [DW-1:0] m_adbus, m_data_rd;
  step_t         m_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] wr_log[$];
  logic [7:0]    dir_log[$];
  int            wr_fall_cyc[$];
  int            wr_low_cnt, rd_low_cnt, tri_cnt;
  logic          prev_wr = 1'b1, prev_rd = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_steps(input int n, input step_t s);
    for (int i = 0; i < n; i++) m_sched.push_back(s);
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples at that edge
  task automatic model_step();
    logic tx_s, rx_s, rel, wel, tw;
    int   wsz, rsz;
    step_t s;
    if (!reset) begin
      m_wq.delete();
      m_rq.delete();
      m_sched.delete();
      for (int i = 0; i < SYNC; i++) begin
        txe_h[i] = 1'b1;
        rxf_h[i] = 1'b1;
      end
      m_last_wr = 1'b0;
      m_run     = 0;
      m_adbus   = '0;
      m_data_rd = '0;
      m_out     = '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b0, cap: 1'b0};
      return;
    end
    tx_s = txe_h[SYNC-1];
    rx_s = rxf_h[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) begin
      txe_h[i] = txe_h[i-1];
      rxf_h[i] = rxf_h[i-1];
    end
    txe_h[0] = txe;
    rxf_h[0] = rxf;
    wsz = m_wq.size();
    rsz = m_rq.size();
    if (m_sched.size() == 0) begin
      rel = rd_en && !rx_s && (rsz < RD);
      wel = wr_en && !tx_s && (wsz > 0);
      if (rel || wel) begin
        if (rel && wel) tw = (m_run < BURST) ? m_last_wr : !m_last_wr;
        else tw = wel;
        m_run     = (tw == m_last_wr) ? m_run + 1 : 1;
        m_last_wr = tw;
        if (tw) begin
          m_adbus = m_wq.pop_front();
          add_steps(SETUP,  '{drv: 1'b1, wr: 1'b1, rd: 1'b1, bsy: 1'b1, cap: 1'b0});
          add_steps(STROBE, '{drv: 1'b1, wr: 1'b0, rd: 1'b1, bsy: 1'b1, cap: 1'b0});
          add_steps(REC,    '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b1, cap: 1'b0});
        end else begin
          add_steps(STROBE, '{drv: 1'b0, wr: 1'b1, rd: 1'b0, bsy: 1'b1, cap: 1'b0});
          add_steps(1,      '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b1, cap: 1'b1});
          add_steps(REC - 1, '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b1, cap: 1'b0});
        end
        add_steps(1, '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b0, cap: 1'b0});
      end
    end
    if (m_sched.size() > 0) s = m_sched.pop_front();
    else s = '{drv: 1'b0, wr: 1'b1, rd: 1'b1, bsy: 1'b0, cap: 1'b0};
    m_out = s;
    if (rdreq && rsz > 0 && !rd_clear) m_data_rd = m_rq.pop_front();
    if (s.cap && !rd_clear && rsz < RD) m_rq.push_back(adbus_in);
    if (wrreq && wsz < WD && !wr_clear) m_wq.push_back(data_wr);
    if (wr_clear) m_wq.delete();
    if (rd_clear) m_rq.delete();
  endtask

  task automatic check_outputs();
    chk("adbus_tri", 32'(adbus_tri), 32'(m_out.drv));
    chk("ftdi_wr",   32'(ftdi_wr),   32'(m_out.wr));
    chk("ftdi_rd",   32'(ftdi_rd),   32'(m_out.rd));
    chk("busy",      32'(busy),      32'(m_out.bsy));
    chk("adbus_out", 32'(adbus_out), 32'(m_adbus));
    chk("data_rd",   32'(data_rd),   32'(m_data_rd));
    chk("rd_qsize",  32'(rd_qsize),  32'(m_rq.size()));
    chk("wr_qsize",  32'(wr_qsize),  32'(m_wq.size()));
    chk("rdq_full",  32'(rdq_full),  32'(m_rq.size() == RD));
    chk("rdq_empty", 32'(rdq_empty), 32'(m_rq.size() == 0));
    chk("wrq_full",  32'(wrq_full),  32'(m_wq.size() == WD));
    chk("wrq_empty", 32'(wrq_empty), 32'(m_wq.size() == 0));
    if (prev_wr && !ftdi_wr) begin
      wr_log.push_back(adbus_out);
      dir_log.push_back(CH_W);
      wr_fall_cyc.push_back(cyc);
    end
    if (prev_rd && !ftdi_rd) dir_log.push_back(CH_R);
    if (!ftdi_wr) wr_low_cnt++;
    if (!ftdi_rd) rd_low_cnt++;
    if (adbus_tri) tri_cnt++;
    prev_wr = ftdi_wr;
    prev_rd = ftdi_rd;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    dir_log.delete();
    wr_fall_cyc.delete();
    wr_low_cnt = 0;
    rd_low_cnt = 0;
    tri_cnt    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rd_clear = 1'b0; wr_clear = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    txe = 1'b1; rxf = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
    adbus_in = '0; data_wr = '0;
    ticks(2);
    reset = 1'b1;
    tick();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    wrreq   = 1'b1;
    data_wr = b;
    tick();
    wrreq   = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] t1_bytes[3];
    t1_bytes[0] = 8'hA5; t1_bytes[1] = 8'h3C; t1_bytes[2] = 8'hFF;
    clear_logs();

    // Reset state
    do_reset();
    chk("rst_ftdi_wr", 32'(ftdi_wr), 32'd1);
    chk("rst_wrq_empty", 32'(wrq_empty), 32'd1);

    // Three queued bytes written out as 2-cycle WR# pulses, 6 cycles apart
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(t1_bytes[i]);
    chk("t1_wr_qsize", 32'(wr_qsize), 32'd3);
    clear_logs();
    txe = 1'b0;
    ticks(40);
    chk("t1_nbytes", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3)
      for (int i = 0; i < 3; i++) chk("t1_byte", 32'(wr_log[i]), 32'(t1_bytes[i]));
    chk("t1_wr_low", 32'(wr_low_cnt), 32'd6);
    chk("t1_tri_cycles", 32'(tri_cnt), 32'd9);
    if (wr_fall_cyc.size() == 3) chk("t1_period", 32'(wr_fall_cyc[2] - wr_fall_cyc[1]), 32'd6);
    chk("t1_wrq_empty", 32'(wrq_empty), 32'd1);

    // Single read of 5A, then popped by the user
    do_reset();
    rd_en = 1'b1; adbus_in = 8'h5A;
    clear_logs();
    rxf = 1'b0;
    n = 0;
    while (ftdi_rd !== 1'b0 && n < 50) begin tick(); n++; end
    chk("t2_rd_start", 32'(n < 50), 32'd1);
    rxf = 1'b1;
    ticks(10);
    chk("t2_rd_low", 32'(rd_low_cnt), 32'd2);
    chk("t2_rd_qsize", 32'(rd_qsize), 32'd1);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("t2_data_rd", 32'(data_rd), 32'h5A);
    chk("t2_rdq_empty", 32'(rdq_empty), 32'd1);

    // Both directions pending: bursts of four alternate
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i * 7 + 1));
    chk("t3_wrq_full", 32'(wrq_full), 32'd1);
    rd_en = 1'b1; wr_en = 1'b1;
    clear_logs();
    txe = 1'b0; rxf = 1'b0;
    for (int i = 0; i < 80; i++) begin
      adbus_in = 8'($urandom);
      tick();
    end
    chk("t3_ntransfers", 32'(dir_log.size() >= 12), 32'd1);
    if (dir_log.size() >= 12)
      for (int i = 0; i < 12; i++) chk("t3_dir", 32'(dir_log[i]), 32'((i >= 4 && i < 8) ? CH_W : CH_R));

    // Read queue fills, stalls, and admits exactly one more read per pop
    do_reset();
    rd_en = 1'b1; adbus_in = 8'hC3;
    rxf = 1'b0;
    n = 0;
    while (rdq_full !== 1'b1 && n < 300) begin tick(); n++; end
    chk("t4_fill", 32'(n < 300), 32'd1);
    chk("t4_rd_qsize", 32'(rd_qsize), 32'(RD));
    clear_logs();
    ticks(20);
    chk("t4_stalled", 32'(dir_log.size()), 32'd0);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    ticks(20);
    chk("t4_one_more", 32'(dir_log.size()), 32'd1);
    chk("t4_full_again", 32'(rdq_full), 32'd1);

    // Reset during the second WR_STROBE cycle
    do_reset();
    wr_en = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    txe = 1'b0;
    n = 0;
    while (ftdi_wr !== 1'b0 && n < 50) begin tick(); n++; end
    chk("t5_strobe", 32'(n < 50), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_ftdi_wr", 32'(ftdi_wr), 32'd1);
    chk("t5_adbus_tri", 32'(adbus_tri), 32'd0);
    chk("t5_wr_qsize", 32'(wr_qsize), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // wr_clear during WR_SETUP: the in-flight byte still goes out, nothing after it
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) push_byte(8'(8'h40 + i));
    txe = 1'b0;
    n = 0;
    while (!(adbus_tri === 1'b1 && ftdi_wr === 1'b1) && n < 50) begin tick(); n++; end
    chk("t6_setup", 32'(n < 50), 32'd1);
    clear_logs();
    wr_clear = 1'b1;
    tick();
    wr_clear = 1'b0;
    ticks(30);
    chk("t6_npulses", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) chk("t6_byte", 32'(wr_log[0]), 32'h40);
    chk("t6_wrq_empty", 32'(wrq_empty), 32'd1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      int ph;
      ph = c / 1500;
      if ($urandom_range(0, 7) == 0) txe = ~txe;
      if ($urandom_range(0, 7) == 0) rxf = ~rxf;
      rd_en    = ($urandom_range(0, 15) != 0);
      wr_en    = ($urandom_range(0, 15) != 0);
      wrreq    = (ph == 1 || ph == 3) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      rdreq    = (ph < 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      data_wr  = 8'($urandom);
      adbus_in = 8'($urandom);
      rd_clear = ($urandom_range(0, 199) == 0);
      wr_clear = ($urandom_range(0, 199) == 0);
      reset    = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1; rd_clear = 1'b0; wr_clear = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    ticks(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_bridge.md
Name: ftdi_fifo_bridge

Overview:
Parametrised successor to the FTDI asynchronous-FIFO interface. It bridges the FT2232-style async FIFO bus (ADBUS, RD#, WR#, RXF#, TXE#) to two internal, self-contained circular-buffer queues, with no vendor FIFO IP. Strobe, setup and recovery timing are set by cycle-count parameters. A read/write arbiter with burst limiting keeps a continuous stream in one direction from starving the other. It sits between the board FTDI pins and the LaserDrop packet logic.

Parameters:
DATA_W, 8, ADBUS and queue word width
RDQ_DEPTH, 1024, read queue depth in words; power of 2, at least 4
WRQ_DEPTH, 1024, write queue depth in words; power of 2, at least 4
SETUP_CYC, 1, cycles data is driven before WR# falls; at least 1
STROBE_CYC, 2, cycles RD# or WR# is held low; at least 1
RECOVER_CYC, 2, cycles all lines are inactive after a strobe
BURST_MAX, 4, consecutive same-direction transfers allowed before yielding to a pending opposite request; at least 1
SYNC_STAGES, 2, flip-flop stages in the txe/rxf synchronisers; at least 2

Ports:
clock  in  1  system clock
reset  in  1  active-low synchronous reset
rd_clear  in  1  empty the read queue
wr_clear  in  1  empty the write queue
rd_en  in  1  permit FTDI reads
wr_en  in  1  permit FTDI writes
txe  in  1  FTDI TXE#, asynchronous, active-low
rxf  in  1  FTDI RXF#, asynchronous, active-low
adbus_in  in  DATA_W  ADBUS input
adbus_out  out  DATA_W  ADBUS output word
adbus_tri  out  1  high = FPGA drives ADBUS
ftdi_rd  out  1  RD#, active-low
ftdi_wr  out  1  WR#, active-low
wrreq  in  1  push data_wr into the write queue
data_wr  in  DATA_W  write queue push data
rdreq  in  1  pop the read queue
data_rd  out  DATA_W  read queue pop data
rdq_full, rdq_empty, wrq_full, wrq_empty  out  1 each  queue status flags
rd_qsize  out  $clog2(RDQ_DEPTH)+1  read queue occupancy
wr_qsize  out  $clog2(WRQ_DEPTH)+1  write queue occupancy
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (reset=0 at a posedge), applied from any state, including mid-strobe:
  - adbus_tri=0, ftdi_rd=1, ftdi_wr=1, adbus_out=0, data_rd=0, busy=0.
  - Both queues empty: empty flags=1, full flags=0, sizes=0.
  - FSM goes to IDLE; burst counter cleared; arbiter preference set to read.
  - Synchroniser flops load 1 (FTDI flags inactive).
- Queues:
  - wrreq while full is dropped. rdreq while empty is ignored and data_rd holds its value.
  - data_rd is registered and valid the cycle after an accepted rdreq.
  - A push and a pop in the same cycle are both performed; the size is unchanged.
  - Pointers wrap modulo depth. Flags and sizes update the cycle after the operation.
  - A clear empties its queue at the next edge and wins over a same-cycle push or pop.
- Synchronisation: FSM decisions use only the txe_s/rxf_s outputs of the SYNC_STAGES chain.
- Eligibility:
  - Read eligible = rd_en && !rxf_s && !rdq_full.
  - Write eligible = wr_en && !txe_s && !wrq_empty.
- FSM states: IDLE, WR_SETUP, WR_STROBE, RD_STROBE, RECOVER.
  - IDLE, arbitration when both directions are eligible: continue the last direction while burst_cnt < BURST_MAX, otherwise switch direction and reset burst_cnt. When only one is eligible, take it; burst_cnt counts same-direction transfers.
  - IDLE to WR_SETUP: pop the write queue; the popped word is held in the adbus_out register.
  - WR_SETUP: adbus_tri=1 for SETUP_CYC cycles.
  - WR_STROBE: adbus_tri=1 and ftdi_wr=0 for STROBE_CYC cycles; adbus_out is stable throughout.
  - RD_STROBE: ftdi_rd=0 and adbus_tri=0 for STROBE_CYC cycles. adbus_in is pushed to the read queue on the final strobe cycle.
  - RECOVER: all lines inactive and adbus_tri=0 for max(RECOVER_CYC, SYNC_STAGES) cycles so stale flags are never acted on. Then go to IDLE.
- Latency:
  - Write transaction = 1 + SETUP_CYC + STROBE_CYC + RECOVER cycles.
  - Read transaction = 1 + STROBE_CYC + RECOVER cycles.
- Mid-transfer events:
  - wr_clear during a write: the in-flight word still completes.
  - rd_clear on the capture cycle: the captured byte is discarded.
  - Deasserting rd_en or wr_en mid-transfer does not abort the transfer.
- adbus_tri and ftdi_wr/ftdi_rd are registered outputs (glitch-free).

Optional Feature:
FTDI_XFER_COUNT_EN:
- Defined: adds 32-bit outputs rd_xfer_cnt and wr_xfer_cnt.
  - Each increments once per completed FTDI transfer (read capture, or the final WR_STROBE cycle).
  - Both reset to 0 and wrap at 2^32.
  - Neither is affected by rd_clear or wr_clear.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults; push A5, 3C, FF; txe=0, wr_en=1 -> three 2-cycle WR# pulses with adbus_out A5, 3C, FF; adbus_tri=1 for 3 cycles per byte; 6 cycles per byte; wrq_empty=1 afterwards.
2. rxf=0, adbus_in=5A, rd_en=1, one transfer -> 2-cycle RD# pulse; rd_qsize=1; rdreq -> data_rd=5A next cycle, rdq_empty=1.
3. rxf=0 and txe=0 held, 16 bytes queued, BURST_MAX=4 -> transfer order R,R,R,R,W,W,W,W,R,... with no direction exceeding 4 in a row.
4. rxf=0 until the read queue holds 1024 words -> rdq_full=1 and RD# stays high; one rdreq -> exactly one further read, then stall again.
5. reset=0 in the second WR_STROBE cycle -> next edge: ftdi_wr=1, adbus_tri=0, wr_qsize=0, busy=0.
6. wr_clear with 10 words queued, asserted during WR_SETUP -> the current byte completes, no further WR# pulses, wrq_empty=1.
